// File: rtl/hazard_scheduler_if.sv
// ID-stage issue bus between the decode stage and the hazard scheduler.
`timescale 1ns/1ps
interface hazard_scheduler_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [3:0]       src1;
   logic [3:0]       src2;
   logic             two_src;
   logic             id_cond_use;
   logic             id_wb_en;
   logic             id_mem_r_en;
   logic             id_s;
   logic [3:0]       id_dest;
   logic             b_taken;
   logic             freeze;
   logic             flush;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_valid, src1, src2, two_src, id_cond_use,
      output id_wb_en, id_mem_r_en, id_s, id_dest, b_taken,
      input  freeze, flush, stall_cnt
   );

   modport slave (
      input  id_valid, src1, src2, two_src, id_cond_use,
      input  id_wb_en, id_mem_r_en, id_s, id_dest, b_taken,
      output freeze, flush, stall_cnt
   );
endinterface

// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: tracks the instructions in EXE and MEM, raises
// freeze on RAW / status hazards against the ID instruction, flush on a
// taken branch, and counts freeze cycles in a saturating counter.
`timescale 1ns/1ps
module hazard_scheduler #(
   parameter bit FORWARD = 1'b0,
   parameter int CNT_W   = 16
) (
   input logic          clk,
   input logic          rst,
   hazard_scheduler_if.slave bus
);

   typedef struct packed {
      logic       valid;
      logic       wb_en;
      logic       mem_r_en;
      logic       s;
      logic [3:0] dest;
   } slot_t;

   slot_t            exe_q;
   slot_t            mem_q;
   slot_t            exe_d;
   logic [CNT_W-1:0] stall_q;

   logic match_exe;
   logic match_mem;
   logic raw_haz;
   logic status_haz;
   logic flush_c;
   logic freeze_c;

   // MEM slot's load/status bits only matter once they would have moved on;
   // they are kept so both slots carry the same record.
   logic unused_slot_bits;
   assign unused_slot_bits = ^{mem_q.mem_r_en, mem_q.s, exe_q.mem_r_en};

   // R15 is compared like any other index.
   function automatic logic slot_match(input slot_t sl, input logic [3:0] a,
                                       input logic [3:0] b, input logic use_b);
      return sl.valid & sl.wb_en & ((sl.dest == a) | (use_b & (sl.dest == b)));
   endfunction

   // Hazard detection; a taken branch kills the ID instruction so it overrides freeze.
   always_comb begin
      match_exe  = slot_match(exe_q, bus.src1, bus.src2, bus.two_src);
      match_mem  = slot_match(mem_q, bus.src1, bus.src2, bus.two_src);
      raw_haz    = 1'b0;
      if (FORWARD)
         raw_haz = bus.id_valid & match_exe & exe_q.mem_r_en;
      else
         raw_haz = bus.id_valid & (match_exe | match_mem);
      status_haz = bus.id_valid & bus.id_cond_use & exe_q.valid & exe_q.s;
      flush_c    = bus.b_taken & exe_q.valid;
      freeze_c   = (raw_haz | status_haz) & ~flush_c;
   end

   // Next EXE contents: a bubble whenever the ID instruction does not issue.
   always_comb begin
      exe_d = '0;
      if (bus.id_valid && !flush_c && !freeze_c) begin
         exe_d.valid    = 1'b1;
         exe_d.wb_en    = bus.id_wb_en;
         exe_d.mem_r_en = bus.id_mem_r_en;
         exe_d.s        = bus.id_s;
         exe_d.dest     = bus.id_dest;
      end
   end

   // Slot pipeline: MEM always takes EXE, EXE takes the issued instruction or a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exe_q <= '0;
         mem_q <= '0;
      end else begin
         mem_q <= exe_q;
         exe_q <= exe_d;
      end
   end

   // Freeze-cycle counter, sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_q <= '0;
      else if (freeze_c && (stall_q != {CNT_W{1'b1}}))
         stall_q <= stall_q + 1'b1;
   end

   assign bus.freeze    = freeze_c;
   assign bus.flush     = flush_c;
   assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: two instances (FORWARD=0 and FORWARD=1, 4-bit
// counter) share one stimulus stream; a cycle-stamped issue-history model is
// compared every cycle, plus hand-computed directed expectations.
`timescale 1ns/1ps
module tb_hazard_scheduler;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [3:0] src1 = '0;
   logic [3:0] src2 = '0;
   logic       two_src = 1'b0;
   logic       id_cond_use = 1'b0;
   logic       id_wb_en = 1'b0;
   logic       id_mem_r_en = 1'b0;
   logic       id_s = 1'b0;
   logic [3:0] id_dest = '0;
   logic       b_taken = 1'b0;

   always #5 clk = ~clk;

   hazard_scheduler_if #(.CNT_W(CW)) ifc0 ();
   hazard_scheduler_if #(.CNT_W(CW)) ifc1 ();

   assign ifc0.id_valid    = id_valid;
   assign ifc0.src1        = src1;
   assign ifc0.src2        = src2;
   assign ifc0.two_src     = two_src;
   assign ifc0.id_cond_use = id_cond_use;
   assign ifc0.id_wb_en    = id_wb_en;
   assign ifc0.id_mem_r_en = id_mem_r_en;
   assign ifc0.id_s        = id_s;
   assign ifc0.id_dest     = id_dest;
   assign ifc0.b_taken     = b_taken;
   assign ifc1.id_valid    = id_valid;
   assign ifc1.src1        = src1;
   assign ifc1.src2        = src2;
   assign ifc1.two_src     = two_src;
   assign ifc1.id_cond_use = id_cond_use;
   assign ifc1.id_wb_en    = id_wb_en;
   assign ifc1.id_mem_r_en = id_mem_r_en;
   assign ifc1.id_s        = id_s;
   assign ifc1.id_dest     = id_dest;
   assign ifc1.b_taken     = b_taken;

   hazard_scheduler #(.FORWARD(1'b0), .CNT_W(CW)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
   hazard_scheduler #(.FORWARD(1'b1), .CNT_W(CW)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int get_fr(input int d);
      return d ? int'(ifc1.freeze) : int'(ifc0.freeze);
   endfunction
   function automatic int get_fl(input int d);
      return d ? int'(ifc1.flush) : int'(ifc0.flush);
   endfunction
   function automatic int get_sc(input int d);
      return d ? int'(ifc1.stall_cnt) : int'(ifc0.stall_cnt);
   endfunction

   // ---------------- model: issue history stamped by cycle number ----------------
   typedef struct {
      int         cyc;
      bit         wb;
      bit         ld;
      bit         s;
      logic [3:0] dest;
   } ent_t;

   ent_t hist0[$];
   ent_t hist1[$];
   int   cyc = 0;
   int   mcnt[2];
   bit   nxt_issue[2];
   bit   nxt_fr[2];

   function automatic bit find(input int d, input int age, output ent_t e);
      ent_t q[$];
      q = d ? hist1 : hist0;
      e = '{0, 0, 0, 0, 4'd0};
      foreach (q[i])
         if (q[i].cyc == cyc - age) begin
            e = q[i];
            return 1'b1;
         end
      return 1'b0;
   endfunction

   function automatic bit writes_src(input ent_t e);
      return e.wb && (e.dest == src1 || (two_src && e.dest == src2));
   endfunction

   initial begin
      mcnt[0] = 0;
      mcnt[1] = 0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            ent_t e1, e2;
            bit   h1, h2, raw, st, fl, fr;
            if (rst) begin
               if (d == 0) hist0.delete(); else hist1.delete();
               mcnt[d] = 0;
               fl = 0;
               fr = 0;
               nxt_issue[d] = 0;
            end else begin
               h1  = find(d, 1, e1);
               h2  = find(d, 2, e2);
               if (d == 1)
                  raw = id_valid && h1 && writes_src(e1) && e1.ld;
               else
                  raw = id_valid && ((h1 && writes_src(e1)) || (h2 && writes_src(e2)));
               st  = id_valid && id_cond_use && h1 && e1.s;
               fl  = b_taken && h1;
               fr  = (raw || st) && !fl;
               nxt_issue[d] = id_valid && !fr && !fl;
            end
            nxt_fr[d] = fr;
            chk($sformatf("model_freeze_fwd%0d", d), get_fr(d), int'(fr));
            chk($sformatf("model_flush_fwd%0d", d), get_fl(d), int'(fl));
            chk($sformatf("model_stall_fwd%0d", d), get_sc(d), mcnt[d]);
         end
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rst) begin
               if (d == 0) hist0.delete(); else hist1.delete();
               mcnt[d] = 0;
            end else begin
               if (nxt_issue[d]) begin
                  ent_t n;
                  n = '{cyc, id_wb_en, id_mem_r_en, id_s, id_dest};
                  if (d == 0) hist0.push_back(n); else hist1.push_back(n);
               end
               if (nxt_fr[d] && mcnt[d] < SAT) mcnt[d]++;
            end
         end
         while (hist0.size() > 3) void'(hist0.pop_front());
         while (hist1.size() > 3) void'(hist1.pop_front());
         cyc++;
      end
   end

   // ---------------- directed stimulus ----------------
   // Called at posedge+1; drives one ID slot, checks literal expectations
   // (-1 = don't care) before the next edge, returns at the next posedge+1.
   task automatic step(input string tag, input bit v, input logic [3:0] s1,
                       input logic [3:0] s2, input bit two, input bit cu,
                       input bit wb, input bit ld, input bit s,
                       input logic [3:0] dst, input bit bt,
                       input int f0, input int f1, input int fl);
      id_valid = v; src1 = s1; src2 = s2; two_src = two; id_cond_use = cu;
      id_wb_en = wb; id_mem_r_en = ld; id_s = s; id_dest = dst; b_taken = bt;
      #3;
      if (f0 >= 0) chk({tag, "_freeze_fwd0"}, get_fr(0), f0);
      if (f1 >= 0) chk({tag, "_freeze_fwd1"}, get_fr(1), f1);
      if (fl >= 0) begin
         chk({tag, "_flush_fwd0"}, get_fl(0), fl);
         chk({tag, "_flush_fwd1"}, get_fl(1), fl);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle2();
      step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk_stall(input string tag, input int e0, input int e1);
      chk({tag, "_stall_fwd0"}, get_sc(0), e0);
      chk({tag, "_stall_fwd1"}, get_sc(1), e1);
   endtask

   initial begin
      int got;
      #3;
      chk("reset_freeze_fwd0", get_fr(0), 0);
      chk("reset_flush_fwd0", get_fl(0), 0);
      chk_stall("reset", 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // ADD R1 then SUB reading R1
      step("add_r1", 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      step("sub_c1", 1, 1, 3, 1, 0, 1, 0, 0, 4, 0, 1, 0, 0);
      step("sub_c2", 1, 1, 3, 1, 0, 1, 0, 0, 4, 0, 1, 0, 0);
      step("sub_c3", 1, 1, 3, 1, 0, 1, 0, 0, 4, 0, 0, 0, 0);
      chk_stall("add_sub", 2, 0);
      idle2();

      // LDR R2 then ADD using R2 as src2
      step("ldr_r2", 1, 13, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0, 0);
      step("lu_c1", 1, 5, 2, 1, 0, 1, 0, 0, 6, 0, 1, 1, 0);
      step("lu_c2", 1, 5, 2, 1, 0, 1, 0, 0, 6, 0, 1, 0, 0);
      step("lu_c3", 1, 5, 2, 1, 0, 1, 0, 0, 6, 0, 0, 0, 0);
      chk_stall("load_use", 4, 1);
      idle2();

      // ADD R2 (no load) then ADD using R2
      step("add_r2", 1, 13, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0);
      step("nl_c1", 1, 5, 2, 1, 0, 1, 0, 0, 6, 0, 1, 0, 0);
      step("nl_c2", 1, 5, 2, 1, 0, 1, 0, 0, 6, 0, 1, 0, 0);
      step("nl_c3", 1, 5, 2, 1, 0, 1, 0, 0, 6, 0, 0, 0, 0);
      chk_stall("no_load", 6, 1);
      idle2();

      // CMP then BEQ
      step("cmp", 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      step("beq_c1", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
      step("beq_c2", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_stall("cmp_beq", 7, 2);
      idle2();

      // hazard and taken branch in the same cycle
      step("br_x", 1, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0);
      step("br_haz", 1, 3, 0, 0, 0, 1, 0, 0, 5, 1, 0, 0, 1);
      step("br_next", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk_stall("branch", 7, 2);
      idle2();

      // id_valid=0 never freezes; src2 ignored without two_src
      step("ldr_r15", 1, 0, 0, 0, 0, 1, 1, 0, 15, 0, 0, 0, 0);
      step("inv_rd", 0, 15, 15, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      step("no_two", 1, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle2();

      // R15 as an ordinary index
      step("ldr_pc", 1, 0, 0, 0, 0, 1, 1, 0, 15, 0, 0, 0, 0);
      step("pc_c1", 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      step("pc_c2", 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step("pc_c3", 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_stall("r15", 9, 3);
      idle2();

      // self-dependent load stream keeps freezing: counters saturate
      for (int i = 0; i < 40; i++)
         step("sat", 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, -1, -1, -1);
      chk_stall("saturate", SAT, SAT);

      // reset asserted while frozen
      got = 0;
      for (int i = 0; i < 6 && got == 0; i++) begin
         #1;
         if (ifc0.freeze) got = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("mid_freeze_found", got, 1);
      rst = 1'b1;
      #1;
      chk("rst_freeze_fwd0", get_fr(0), 0);
      chk("rst_freeze_fwd1", get_fr(1), 0);
      chk_stall("rst_mid", 0, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      step("post_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_stall("post_rst", 0, 0);
      idle2();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      fails++;
      $display("FAIL watchdog: time limit reached before end of sequence");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 Parameter FORWARD, default 0: 0 = stall on any RAW against EXE/MEM slots; 1 = stall only on load-use (EXE slot load).
REQ-002 Parameter CNT_W, default 16: width of stall counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset is asynchronous and active-high.
REQ-005 id_valid  in  1  ID stage holds a valid instruction.
REQ-006 src1  in  4  Rn index of ID instruction.
REQ-007 src2  in  4  Rm/Rd-for-store index of ID instruction.
REQ-008 two_src  in  1  ID instruction reads src2 (register operand or store).
REQ-009 id_cond_use  in  1  ID instruction condition is not AL (reads status).
REQ-010 id_wb_en, id_mem_r_en, id_s  in  1 each  ID instruction writes back / is load / updates status.
REQ-011 id_dest  in  4  ID destination register.
REQ-012 b_taken  in  1  branch resolved taken by the instruction in EXE.
REQ-013 freeze  out  1  hold PC and IF/ID registers; insert bubble into EXE.
REQ-014 flush  out  1  kill IF/ID contents (branch taken).
REQ-015 stall_cnt  out  CNT_W  saturating count of freeze cycles.

Function
REQ-016 Block SHALL hold two internal slots, EXE and MEM, each {valid, wb_en, mem_r_en, s, dest}.
REQ-017 Match SHALL be: slot.valid & slot.wb_en & (slot.dest==src1 | (two_src & slot.dest==src2)).
REQ-018 With FORWARD=0, raw_haz SHALL = id_valid & (match(EXE) | match(MEM)).
REQ-019 With FORWARD=1, raw_haz SHALL = id_valid & match(EXE) & EXE.mem_r_en; MEM-slot matches SHALL NOT stall.
REQ-020 status_haz SHALL = id_valid & id_cond_use & EXE.valid & EXE.s (status register written at end of EXE cycle).
REQ-021 flush SHALL = b_taken & EXE.valid, combinational, same cycle.
REQ-022 freeze SHALL = (raw_haz | status_haz) & ~flush, combinational, same cycle; flush has priority.
REQ-023 On each edge: MEM slot SHALL load EXE slot contents unconditionally.
REQ-024 On each edge: EXE slot SHALL load a bubble (valid=0) if flush or freeze or ~id_valid; otherwise load {1, id_wb_en, id_mem_r_en, id_s, id_dest}.
REQ-025 Freeze latency: hazard resolves without further input; load-use with FORWARD=1 SHALL freeze exactly 1 cycle; RAW with FORWARD=0 SHALL freeze 2 cycles against EXE, 1 against MEM only.
REQ-026 stall_cnt SHALL increment by 1 on each edge where freeze=1, saturating at all-ones (no wrap).
REQ-027 Simultaneous flush and hazard: flush SHALL win, freeze=0, stall_cnt unchanged, EXE slot gets bubble.
REQ-028 Register index 15 (PC) SHALL be treated as an ordinary index for matching; no special case.
REQ-029 Inputs with id_valid=0 SHALL never cause freeze.

Reset
REQ-030 On rst asserted, asynchronously: EXE and MEM slots valid=0, stall_cnt=0; hence freeze=0, flush=0 while rst held.
REQ-031 rst asserted mid-freeze SHALL clear all state immediately; first post-reset cycle SHALL see no hazard from pre-reset slots.

Verification
REQ-032 FORWARD=0: issue ADD R1 (wb_en, dest=1), next cycle SUB reading src1=1 -> freeze=1 for 2 cycles, SUB issues on 3rd, stall_cnt=2.
REQ-033 FORWARD=1: LDR R2 (mem_r_en, dest=2), next ADD src2=2 two_src=1 -> freeze=1 one cycle, stall_cnt=1; same with ADD (no load) -> freeze=0.
REQ-034 CMP (id_s=1) then BEQ (id_cond_use=1) -> freeze=1 one cycle, then BEQ issues.
REQ-035 Hazard present and b_taken=1 with EXE.valid=1 same cycle -> flush=1, freeze=0, next-cycle EXE slot invalid.
REQ-036 Force freeze continuously 2^CNT_W+3 cycles -> stall_cnt holds at all-ones; rst pulse mid-run -> stall_cnt=0, freeze=0 immediately.
